// File: rtl/mul_int_pkg.sv
// Shared definitions for the mul_int arithmetic unit: FSM encoding,
// iteration count and the radix-4 Booth digit decode.
package mul_int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    PP_ZERO,
    PP_POS_X,
    PP_POS_2X,
    PP_NEG_X,
    PP_NEG_2X
  } booth_sel_t;

  // One digit per iteration over N+2 bits of operand.
  function automatic int booth_iter(input int n);
    return n / 2 + 1;
  endfunction

  function automatic booth_sel_t booth_decode(input logic [2:0] digit);
    booth_sel_t sel;
    case (digit)
      3'b001, 3'b010: sel = PP_POS_X;
      3'b011:         sel = PP_POS_2X;
      3'b100:         sel = PP_NEG_2X;
      3'b101, 3'b110: sel = PP_NEG_X;
      default:        sel = PP_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_radix4_mul_seq_if.sv
// Operand/result bundle of the sequential Booth multiplier.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1; valid, once raised, holds its payload stable until that edge.
interface booth_radix4_mul_seq_if
  import mul_int_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      is_signed;
  logic [DATA_WIDTH-1:0]     a;
  logic [DATA_WIDTH-1:0]     b;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [2*DATA_WIDTH-1:0]   product;
  logic                      busy;
  state_t                    state;

  modport slave (
    input  in_valid, is_signed, a, b, flush, out_ready,
    output in_ready, out_valid, product, busy, state
  );

  modport master (
    output in_valid, is_signed, a, b, flush, out_ready,
    input  in_ready, out_valid, product, busy, state
  );
endinterface

// File: rtl/booth_pp_sel.sv
// Combinational radix-4 Booth partial-product selector. Negative multiples
// are returned as the one's complement plus a carry-in bit c.
module booth_pp_sel
  import mul_int_pkg::*;
#(
  parameter int W = 34
) (
  input  logic [2:0]   digit,
  input  logic [W-1:0] x,
  output logic [W-1:0] pp,
  output logic         c
);
  logic [W-1:0] x2;

  // x is already extended by two bits, so the doubling cannot overflow.
  assign x2 = {x[W-2:0], 1'b0};

  always_comb begin
    pp = '0;
    c  = 1'b0;
    case (booth_decode(digit))
      PP_POS_X:  pp = x;
      PP_POS_2X: pp = x2;
      PP_NEG_X:  begin pp = ~x;  c = 1'b1; end
      PP_NEG_2X: begin pp = ~x2; c = 1'b1; end
      default:   pp = '0;
    endcase
  end
endmodule

// File: rtl/booth_radix4_mul_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, runtime
// signed/unsigned, valid/ready on both sides, synchronous flush.
module booth_radix4_mul_seq
  import mul_int_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_radix4_mul_seq_if.slave bus
);
  localparam int N     = DATA_WIDTH;
  localparam int W     = N + 2;
  localparam int ITER  = booth_iter(N);
  localparam int CNT_W = $clog2(ITER);

  state_t            state_q, state_d;
  logic [W-1:0]      x_q;
  logic [W:0]        yx_q;
  logic [2*N-1:0]    acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic              last_iter;
  logic [W-1:0]      a_ext, b_ext;
  logic [W:0]        yx_sh;
  logic [2:0]        digit;
  logic [W-1:0]      pp;
  logic              pp_c;
  logic [2*N-1:0]    pp_ext;
  logic [2*N-1:0]    addend;

  assign a_ext = bus.is_signed ? {{2{bus.a[N-1]}}, bus.a} : {2'b00, bus.a};
  assign b_ext = bus.is_signed ? {{2{bus.b[N-1]}}, bus.b} : {2'b00, bus.b};

  assign accept    = (state_q == IDLE) && bus.in_valid && !bus.flush;
  assign last_iter = (cnt_q == CNT_W'(ITER - 1));

  assign yx_sh = yx_q >> {cnt_q, 1'b0};
  assign digit = yx_sh[2:0];

  booth_pp_sel #(.W(W)) u_pp_sel (
    .digit (digit),
    .x     (x_q),
    .pp    (pp),
    .c     (pp_c)
  );

  // Only the low 2N bits of the exact sum are ever observed, and carries
  // propagate upward only, so the accumulator is kept at 2N bits.
  assign pp_ext = {{(2*N-W){pp[W-1]}}, pp};
  assign addend = (pp_ext + {{(2*N-1){1'b0}}, pp_c}) << {cnt_q, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.in_valid)  state_d = BUSY;
        BUSY:    if (last_iter)     state_d = DONE;
        DONE:    if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      yx_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      x_q   <= a_ext;
      yx_q  <= {b_ext, 1'b0};
      acc_q <= '0;
      cnt_q <= '0;
    end else if ((state_q == BUSY) && !bus.flush) begin
      acc_q <= acc_q + addend;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.product   = acc_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_booth_radix4_mul_seq.sv
// Bench for booth_radix4_mul_seq: an 8-bit and a 32-bit instance checked
// against plain-arithmetic products and the documented cycle timing.
module tb_booth_radix4_mul_seq;
  import mul_int_pkg::*;

  localparam int ITER8  = 5;
  localparam int ITER32 = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] exp_q[$];
  int          acc_cyc_q[$];

  always #5 clk = ~clk;

  booth_radix4_mul_seq_if #(.DATA_WIDTH(8))  m8();
  booth_radix4_mul_seq_if #(.DATA_WIDTH(32)) m32();

  booth_radix4_mul_seq #(.DATA_WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(m8.slave));
  booth_radix4_mul_seq #(.DATA_WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(m32.slave));

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int pa, pb;
    pa = s ? int'($signed(a)) : int'(a);
    pb = s ? int'($signed(b)) : int'(b);
    return 16'(pa * pb);
  endfunction

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'({32'b0, a});
    pb = s ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(pa * pb);
  endfunction

  // Called at a negedge with the 8-bit DUT idle. lat = edges after the
  // accepting edge until out_valid is seen, or -1 on timeout.
  task automatic drive_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                           output logic [15:0] prod, output int lat);
    m8.a = a; m8.b = b; m8.is_signed = s; m8.in_valid = 1'b1;
    @(negedge clk);
    m8.in_valid = 1'b0;
    m8.a = 8'($urandom); m8.b = 8'($urandom); m8.is_signed = 1'($urandom);
    lat = 0;
    while (!m8.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!m8.out_valid) lat = -1;
    prod = m8.product;
    m8.out_ready = 1'b1;
    @(negedge clk);
    m8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready8 got %b want 1", m8.in_ready); end
    checks++; if (m8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid8 got %b want 0", m8.out_valid); end
    checks++; if (m8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy8 got %b want 0", m8.busy); end
    checks++; if (m8.product !== 16'h0) begin errors++; $display("FAIL reset_product8 got %h want 0000", m8.product); end
    checks++; if (m32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready32 got %b want 1", m32.in_ready); end
    checks++; if (m32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid32 got %b want 0", m32.out_valid); end
    checks++; if (m32.product !== 64'h0) begin errors++; $display("FAIL reset_product32 got %h want 0", m32.product); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_corners8();
    logic [7:0]  va[7] = '{8'h80, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h80, 8'h7F};
    logic [7:0]  vb[7] = '{8'h80, 8'hFF, 8'hFF, 8'hFD, 8'h5A, 8'h80, 8'h80};
    logic        vs[7] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
    logic [15:0] ve[7] = '{16'h4000, 16'hFE01, 16'h0001, 16'hFFEB, 16'h0000, 16'h4000, 16'hC080};
    logic [15:0] prod;
    int lat;
    logic [7:0] a, b;
    logic s;
    for (int i = 0; i < 7; i++) begin
      drive_op8(va[i], vb[i], vs[i], prod, lat);
      checks++; if (prod !== ve[i]) begin errors++; $display("FAIL corner8_%0d_product got %h want %h", i, prod, ve[i]); end
      checks++; if (lat != ITER8) begin errors++; $display("FAIL corner8_%0d_latency got %0d want %0d", i, lat, ITER8); end
    end
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      drive_op8(a, b, s, prod, lat);
      checks++; if (prod !== ref8(a, b, s) || lat != ITER8) begin
        errors++; $display("FAIL rand8 a=%h b=%h s=%b got %h lat %0d want %h lat %0d", a, b, s, prod, lat, ref8(a, b, s), ITER8);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    int n;
    m8.a = 8'd13; m8.b = 8'd11; m8.is_signed = 1'b0; m8.in_valid = 1'b1;
    @(negedge clk);
    m8.in_valid = 1'b0;
    n = 0;
    while (!m8.out_valid && n < 50) begin @(negedge clk); n++; end
    checks++; if (m8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got out_valid %b want 1", m8.out_valid); end
    held = m8.product;
    checks++; if (held !== 16'h008F) begin errors++; $display("FAIL bp_product got %h want 008f", held); end
    for (int i = 0; i < 10; i++) begin
      m8.in_valid = 1'b1; m8.a = 8'($urandom); m8.b = 8'($urandom);
      @(negedge clk);
      checks++; if (m8.out_valid !== 1'b1 || m8.product !== held || m8.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d got ov=%b p=%h ir=%b want ov=1 p=%h ir=0", i, m8.out_valid, m8.product, m8.in_ready, held);
      end
    end
    m8.in_valid = 1'b0; m8.out_ready = 1'b1;
    @(negedge clk);
    m8.out_ready = 1'b0;
    checks++; if (m8.in_ready !== 1'b1 || m8.out_valid !== 1'b0 || m8.busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got ir=%b ov=%b busy=%b want 1 0 0", m8.in_ready, m8.out_valid, m8.busy);
    end
  endtask

  task automatic test_abort();
    logic [15:0] prod;
    int lat;
    bit seen;
    m8.a = 8'h55; m8.b = 8'h33; m8.is_signed = 1'b0; m8.in_valid = 1'b1;
    @(negedge clk);
    m8.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (m8.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre_reset got %b want 1", m8.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (m8.in_ready !== 1'b1 || m8.out_valid !== 1'b0 || m8.busy !== 1'b0 || m8.product !== 16'h0) begin
      errors++; $display("FAIL abort_reset got ir=%b ov=%b busy=%b p=%h want 1 0 0 0000", m8.in_ready, m8.out_valid, m8.busy, m8.product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m8.in_valid = 1'b1;
    @(negedge clk);
    m8.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    m8.flush = 1'b1;
    @(negedge clk);
    m8.flush = 1'b0;
    checks++; if (m8.state !== IDLE || m8.out_valid !== 1'b0 || m8.in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_flush got st=%0d ov=%b ir=%b want 0 0 1", m8.state, m8.out_valid, m8.in_ready);
    end
    seen = 1'b0;
    repeat (ITER8 + 3) begin @(negedge clk); if (m8.out_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL abort_flush_no_result got out_valid 1 want 0"); end
    m8.flush = 1'b1; m8.in_valid = 1'b1;
    @(negedge clk);
    m8.flush = 1'b0; m8.in_valid = 1'b0;
    checks++; if (m8.busy !== 1'b0) begin errors++; $display("FAIL abort_flush_vs_valid got busy %b want 0", m8.busy); end
    drive_op8(8'h55, 8'h33, 1'b0, prod, lat);
    checks++; if (prod !== 16'h10EF || lat != ITER8) begin
      errors++; $display("FAIL abort_recover got %h lat %0d want 10ef lat %0d", prod, lat, ITER8);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int done_ops = 0;
    int acc_cnt = 0;
    int lat;
    bit hs_prev = 1'b0;
    logic [31:0] a, b;
    logic s;
    logic [63:0] e;
    exp_q.delete();
    acc_cyc_q.delete();
    m32.out_ready = 1'b1;
    while (done_ops < 20 && cyc < 1000) begin
      if (hs_prev) begin
        checks++; if (m32.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_hs got %b want 1", m32.in_ready); end
      end
      hs_prev = 1'b0;
      if (m32.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_spurious got out_valid 1 want 0");
        end else begin
          e = exp_q.pop_front();
          lat = cyc - acc_cyc_q.pop_front() - 1;
          checks++; if (m32.product !== e || lat != ITER32) begin
            errors++; $display("FAIL b2b_result got %h lat %0d want %h lat %0d", m32.product, lat, e, ITER32);
          end
        end
        hs_prev = 1'b1;
        done_ops++;
      end
      if (m32.in_ready && acc_cnt < 20) begin
        a = $urandom; b = $urandom; s = 1'($urandom);
        m32.a = a; m32.b = b; m32.is_signed = s; m32.in_valid = 1'b1;
        exp_q.push_back(ref32(a, b, s));
        acc_cyc_q.push_back(cyc);
        acc_cnt++;
      end else begin
        m32.in_valid = (acc_cnt < 20);
        m32.a = $urandom; m32.b = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (done_ops != 20) begin errors++; $display("FAIL b2b_count got %0d want 20", done_ops); end
    m32.in_valid = 1'b0;
    m32.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random32();
    logic [31:0] a, b;
    logic s;
    logic [63:0] e;
    int lat;
    int stall;
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 3)) begin
        m32.in_valid = 1'b0; m32.a = $urandom; m32.b = $urandom;
        m32.out_ready = 1'($urandom);
        @(negedge clk);
      end
      checks++; if (m32.in_ready !== 1'b1) begin errors++; $display("FAIL rand32_%0d_in_ready got %b want 1", i, m32.in_ready); end
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      e = ref32(a, b, s);
      m32.a = a; m32.b = b; m32.is_signed = s; m32.in_valid = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!m32.out_valid && lat < 60) begin
        m32.in_valid = 1'($urandom); m32.a = $urandom; m32.b = $urandom; m32.is_signed = 1'($urandom);
        m32.out_ready = 1'($urandom);
        @(negedge clk);
        lat++;
      end
      m32.in_valid = 1'b0;
      m32.out_ready = 1'b0;
      checks++; if (m32.product !== e || lat != ITER32) begin
        errors++; $display("FAIL rand32_%0d a=%h b=%h s=%b got %h lat %0d want %h lat %0d", i, a, b, s, m32.product, lat, e, ITER32);
      end
      if (lat >= 60) begin
        $display("FAIL rand32_timeout op %0d got no out_valid want out_valid", i);
        break;
      end
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      if (stall > 0) begin
        checks++; if (m32.out_valid !== 1'b1 || m32.product !== e) begin
          errors++; $display("FAIL rand32_%0d_stall got ov=%b p=%h want 1 %h", i, m32.out_valid, m32.product, e);
        end
      end
      m32.out_ready = 1'b1;
      @(negedge clk);
      m32.out_ready = 1'b0;
    end
  endtask

  initial begin
    m8.in_valid = 1'b0;  m8.is_signed = 1'b0;  m8.a = '0;  m8.b = '0;  m8.flush = 1'b0;  m8.out_ready = 1'b0;
    m32.in_valid = 1'b0; m32.is_signed = 1'b0; m32.a = '0; m32.b = '0; m32.flush = 1'b0; m32.out_ready = 1'b0;
    test_reset();
    test_corners8();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_random32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
